// File: rtl/output_gain_if.sv
// rtl/output_gain_if.sv - sample/gain bundle between the channel strip and the output gain stage
interface output_gain_if #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16
);
  logic        [GAIN_W-1:0] gain;
  logic signed [DATA_W-1:0] outputGainIn;
  logic signed [DATA_W-1:0] outputGainOut;
  logic                     clip;

  modport master (
    output gain,
    output outputGainIn,
    input  outputGainOut,
    input  clip
  );

  modport slave (
    input  gain,
    input  outputGainIn,
    output outputGainOut,
    output clip
  );
endinterface

// File: rtl/output_gain.sv
// rtl/output_gain.sv - Q4.12 output gain with optional slew-limited gain, round-half-up and saturation
module output_gain #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 12,
  parameter int RAMP_STEP = 0
) (
  input  logic          clk_48,
  input  logic          reset_n,
  output_gain_if.slave  io
);

  localparam int PW = DATA_W + GAIN_W + 1;

  localparam logic        [GAIN_W-1:0] UNITY_C = GAIN_W'(1 << GAIN_FRAC);
  localparam logic        [GAIN_W-1:0] STEP_C  = GAIN_W'(RAMP_STEP);
  localparam logic signed [PW-1:0]     HALF_C  = PW'(1 << (GAIN_FRAC - 1));
  localparam logic signed [PW-1:0]     MAX_C   = PW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0]     MIN_C   = ~MAX_C;

  logic signed [DATA_W-1:0] in_q, in_d;
  logic        [GAIN_W-1:0] g_app_q, g_app_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     clip_q, clip_d;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] shifted;

  // Stage 1: capture sample and slew the applied gain toward the target without overshoot.
  always_comb begin
    in_d    = io.outputGainIn;
    g_app_d = io.gain;
    if (RAMP_STEP != 0) begin
      if (io.gain > g_app_q) begin
        if ((io.gain - g_app_q) > STEP_C) begin
          g_app_d = g_app_q + STEP_C;
        end
      end else if ((g_app_q - io.gain) > STEP_C) begin
        g_app_d = g_app_q - STEP_C;
      end
    end
  end

  // Stage 2: gain is zero-extended so the product stays signed at full precision.
  always_comb begin
    prod    = PW'(in_q) * PW'($signed({1'b0, g_app_q}));
    rnd     = prod + HALF_C;
    shifted = rnd >>> GAIN_FRAC;
    out_d   = shifted[DATA_W-1:0];
    clip_d  = 1'b0;
    if (shifted > MAX_C) begin
      out_d  = MAX_C[DATA_W-1:0];
      clip_d = 1'b1;
    end else if (shifted < MIN_C) begin
      out_d  = MIN_C[DATA_W-1:0];
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= '0;
      g_app_q <= UNITY_C;
      out_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      in_q    <= in_d;
      g_app_q <= g_app_d;
      out_q   <= out_d;
      clip_q  <= clip_d;
    end
  end

  assign io.outputGainOut = out_q;
  assign io.clip          = clip_q;

endmodule

// File: tb/tb_output_gain.sv
// tb/tb_output_gain.sv - directed and random checks of output_gain, flat and ramped gain instances
module tb_output_gain;

  logic clk_48 = 1'b0;
  logic reset_n;

  always #5 clk_48 = ~clk_48;

  output_gain_if #(.DATA_W(16), .GAIN_W(16)) io0 ();
  output_gain_if #(.DATA_W(16), .GAIN_W(16)) io1 ();

  output_gain #(.DATA_W(16), .GAIN_W(16), .GAIN_FRAC(12), .RAMP_STEP(0)) u_flat (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .io      (io0)
  );

  output_gain #(.DATA_W(16), .GAIN_W(16), .GAIN_FRAC(12), .RAMP_STEP(256)) u_ramp (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .io      (io1)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: last captured sample and applied gain of each instance
  int m_in, m_g0, m_g1;
  int exp0, exp1, expc0, expc1;
  int last0, last1, lclip0, lclip1;

  function automatic longint scaled(int x, int g);
    longint p;
    p = longint'(x) * longint'(g) + 64'sd2048;
    return p >>> 12;
  endfunction

  function automatic int sat(longint r);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
  endfunction

  function automatic int over(longint r);
    return (r > 32767 || r < -32768) ? 1 : 0;
  endfunction

  function automatic int ramp_to(int cur, int tgt, int stp);
    int d;
    d = tgt - cur;
    if (d < 0) d = -d;
    if (stp == 0 || d <= stp) return tgt;
    return (tgt > cur) ? cur + stp : cur - stp;
  endfunction

  task automatic chk(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_in = 0;
    m_g0 = 4096;
    m_g1 = 4096;
  endtask

  task automatic step(int x, int g);
    io0.outputGainIn = 16'(x);
    io1.outputGainIn = 16'(x);
    io0.gain         = 16'(g);
    io1.gain         = 16'(g);
    @(posedge clk_48);
    exp0  = sat(scaled(m_in, m_g0));
    expc0 = over(scaled(m_in, m_g0));
    exp1  = sat(scaled(m_in, m_g1));
    expc1 = over(scaled(m_in, m_g1));
    m_in  = x;
    m_g0  = g;
    m_g1  = ramp_to(m_g1, g, 256);
    #1;
    last0  = int'($signed(io0.outputGainOut));
    last1  = int'($signed(io1.outputGainOut));
    lclip0 = int'(io0.clip);
    lclip1 = int'(io1.clip);
    chk("flat_out", last0, exp0);
    chk("flat_clip", lclip0, expc0);
    chk("ramp_out", last1, exp1);
    chk("ramp_clip", lclip1, expc1);
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_out0"}, int'($signed(io0.outputGainOut)), 0);
    chk({tag, "_clip0"}, int'(io0.clip), 0);
    chk({tag, "_out1"}, int'($signed(io1.outputGainOut)), 0);
    chk({tag, "_clip1"}, int'(io1.clip), 0);
  endtask

  initial begin
    int sine[48];
    int hin[4];
    int hexp[4];
    int g;
    logic [15:0] r16;

    hin  = '{4277, -4277, -32767, 32767};
    hexp = '{2139, -2138, -16383, 16384};
    for (int k = 0; k < 48; k++) begin
      sine[k] = int'(32767.0 * $sin(2.0 * 3.14159265358979 * k / 48.0));
    end

    // reset held with arbitrary input
    reset_n          = 1'b0;
    io0.outputGainIn = 16'h7abc;
    io1.outputGainIn = 16'h7abc;
    io0.gain         = 16'h3000;
    io1.gain         = 16'h3000;
    repeat (3) @(posedge clk_48);
    #1;
    check_cleared("reset");
    @(negedge clk_48);
    reset_n = 1'b1;
    model_reset();

    step(16384, 4096);
    step(0, 4096);
    chk("first_valid_flat", last0, 16384);
    chk("first_valid_ramp", last1, 16384);

    // unity pass-through of a sine: output is input two edges late
    for (int k = 0; k < 48; k++) begin
      step(sine[k], 4096);
      if (k >= 1) begin
        chk("unity_sine", last0, sine[k-1]);
        chk("unity_noclip", lclip0, 0);
      end
    end

    // gain 2.0 saturation
    step(32767, 16'h2000);
    step(-32767, 16'h2000);
    chk("g2_pos_sat", last0, 32767);
    chk("g2_pos_clip", lclip0, 1);
    step(12539, 16'h2000);
    chk("g2_neg_sat", last0, -32768);
    chk("g2_neg_clip", lclip0, 1);
    step(0, 16'h2000);
    chk("g2_linear", last0, 25078);
    chk("g2_linear_clip", lclip0, 0);

    // gain 0.5 round-half-up
    step(hin[0], 16'h0800);
    for (int i = 1; i <= 4; i++) begin
      step((i < 4) ? hin[i] : 0, 16'h0800);
      chk("half_round", last0, hexp[i-1]);
    end

    // extremes and asymmetric unity
    step(-32768, 16'hFFFF);
    step(32767, 0);
    chk("max_gain_neg", last0, -32768);
    chk("max_gain_clip", lclip0, 1);
    step(-32768, 4096);
    chk("zero_gain", last0, 0);
    chk("zero_gain_clip", lclip0, 0);
    step(0, 4096);
    chk("unity_min", last0, -32768);
    chk("unity_min_clip", lclip0, 0);

    // settle both at unity, then switch to 2.0
    for (int i = 0; i < 40; i++) step(4096, 4096);
    for (int i = 1; i <= 18; i++) begin
      step(4096, 16'h2000);
      if (i == 1) begin
        chk("switch_flat_e1", last0, 4096);
        chk("switch_ramp_e1", last1, 4096);
      end
      if (i == 2) begin
        chk("switch_flat_e2", last0, 8192);
        chk("ramp_first", last1, 4352);
      end
      if (i == 3) chk("ramp_second", last1, 4608);
      if (i == 16) chk("ramp_penult", last1, 7936);
      if (i >= 17) chk("ramp_done", last1, 8192);
    end

    // gain switch mid-sine, plus a ramp retarget downward
    for (int k = 0; k < 48; k++) begin
      step(sine[k], (k < 24) ? 4096 : 16'h2000);
    end
    for (int k = 0; k < 12; k++) begin
      step(sine[k], (k < 6) ? 16'h0100 : 16'h3000);
    end

    // random stimulus with an asynchronous reset mid-stream
    g = 4096;
    for (int i = 0; i < 320; i++) begin
      if (i % 8 == 0) g = int'($urandom_range(0, 65535));
      if (i % 37 == 5) g = 4096;
      r16 = 16'($urandom);
      step(int'($signed(r16)), g);
      if (i == 160) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_cleared("async_reset");
        @(posedge clk_48);
        @(negedge clk_48);
        reset_n = 1'b1;
        model_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_gain.md
Name: output_gain

Overview:
- Final output-level stage of the channel-strip processing chain.
- Multiplies each signed 16-bit audio sample by an unsigned Q4.12 gain word, rounds the result, saturates it and registers it.
- Runs one sample per clock on the 48 kHz sample clock.
- An optional gain ramp limits how fast the applied gain can move, to suppress zipper noise on gain changes.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- GAIN_W, 16, gain word width (unsigned).
- GAIN_FRAC, 12, fractional bits of gain; 1 << GAIN_FRAC is unity (0x1000).
- RAMP_STEP, 0, maximum change of applied gain per clock in gain LSBs; 0 means the target gain is taken directly each cycle (no ramp).

Ports:
- clk_48  in  1  sample clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- gain  in  GAIN_W  target gain, unsigned Q4.12 (0x0800 = 0.5, 0x1000 = 1.0, 0x2000 = 2.0, 0xFFFF ≈ 15.9998).
- outputGainIn  in  DATA_W  signed input sample, one new sample per clock.
- outputGainOut  out  DATA_W  signed, gained, rounded and saturated sample.
- clip  out  1  high for exactly the cycles in which outputGainOut is a saturated value.

Behaviour:
- Reset (reset_n low, asynchronous):
  - outputGainOut = 0, clip = 0.
  - Input pipeline register = 0.
  - Applied-gain register g_app = 0x1000 (unity).
  - Reset asserted mid-stream clears all of this immediately. The first valid output appears 2 rising edges after reset_n is released.
- Stage 1, every rising edge:
  - in_r <= outputGainIn.
  - If RAMP_STEP == 0: g_app <= gain.
  - Otherwise g_app moves toward gain:
    - If |gain − g_app| <= RAMP_STEP, g_app <= gain.
    - Else g_app <= g_app ± RAMP_STEP, in the direction of gain.
  - g_app never overshoots the target.
  - gain is re-read every cycle. If the target changes mid-ramp, the ramp retargets immediately.
- Stage 2, every rising edge:
  - Full-precision product p = in_r × {0, g_app}: a signed 17-bit zero-extended gain gives a signed 33-bit product, with no intermediate truncation.
  - Rounding is round-half-up: r = (p + 2^(GAIN_FRAC−1)) >>> GAIN_FRAC (arithmetic shift).
  - Saturation:
    - r > 32767 → outputGainOut = 32767, clip = 1.
    - r < −32768 → outputGainOut = −32768, clip = 1.
    - Otherwise outputGainOut = r[15:0], clip = 0.
- Latency: an input sample or gain value present at edge N affects outputGainOut and clip after edge N+1 (2 registers). Throughput is 1 sample per clock.
- Gain 0 gives output 0 for any input. Unity gain is exactly transparent.
- Sign handling is symmetric except for saturation: −32768 × unity = −32768, not clipped.
- All arithmetic is combinational within stage 2. No multicycle paths.

Test Plan:
- Reset: hold reset_n low with arbitrary input → outputGainOut = 0, clip = 0. Release reset, apply in = 16384 with gain 0x1000 → 16384 two edges later.
- Unity pass-through: 48-sample 1 kHz sine (peak ±32767, e.g. 4277, 8481 …), gain 0x1000 → output equals input delayed 2 cycles; clip never asserted.
- Gain 2.0 saturation: gain 0x2000 →
  - in 32767 → 32767, clip = 1.
  - in −32767 → −32768, clip = 1.
  - in 12539 → 25078, clip = 0.
- Gain 0.5 rounding: gain 0x0800 →
  - in 4277 → 2139.
  - in −4277 → −2138.
  - in −32767 → −16383.
  - in 32767 → 16384.
- Extremes: gain 0xFFFF with in −32768 → −32768, clip = 1. Gain 0 with in 32767 → 0.
- Gain switch and ramp:
  - RAMP_STEP = 0: switching gain 0x1000 → 0x2000 mid-sine changes the output on exactly the 2nd edge after the switch.
  - RAMP_STEP = 0x0100: the same switch reaches 0x2000 after 16 edges. With in = 4096, outputs step 4352, 4608, … up to 8192.
